// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with a 4-byte command packet decoder (header, opcode, arg, checksum)
// driving the sensor transmitter's streaming enable and debug byte.
`timescale 1ns/1ps
module uart_cmd_rx #(
    parameter int         CLOCK_RATE   = 100_000_000,
    parameter int         BAUD_RATE    = 115_200,
    parameter logic [7:0] HDR_BYTE     = 8'hA5,
    parameter int         TIMEOUT_BITS = 32
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err,
    output logic       cmd_valid,
    output logic [7:0] cmd_opcode,
    output logic [7:0] cmd_arg,
    output logic       cmd_err,
    output logic       uart_active,
    output logic [7:0] debug_out
);
    localparam int CYC    = CLOCK_RATE / BAUD_RATE;
    localparam int HALF   = CYC / 2;
    localparam int TO_CYC = TIMEOUT_BITS * CYC;
    localparam int CW     = $clog2(CYC + 1);
    localparam int TW     = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_e;
    typedef enum logic [1:0] {P_WAIT_HDR, P_GET_OP, P_GET_ARG, P_GET_SUM} pstate_e;

    bstate_e       bstate_q;
    pstate_e       pstate_q;
    logic          sync1_q, rx_s_q, rx_prev_q;
    logic [CW-1:0] bcnt_q;
    logic [2:0]    bitn_q;
    logic [7:0]    shift_q, rx_byte_q;
    logic          rx_byte_valid_q, frame_err_q;
    logic [TW-1:0] gap_q;
    logic [7:0]    op_q, arg_q, cmd_opcode_q, cmd_arg_q, debug_q;
    logic          cmd_valid_q, cmd_err_q, uart_active_q;

    logic bit_tick, stop_good, stop_bad;

    // START waits half a bit to land mid-bit; every later sample is a full bit apart.
    assign bit_tick  = (bstate_q == B_START) ? (bcnt_q == CW'(HALF - 1)) : (bcnt_q == CW'(CYC - 1));
    assign stop_good = (bstate_q == B_STOP) && bit_tick && rx_s_q;
    assign stop_bad  = (bstate_q == B_STOP) && bit_tick && !rx_s_q;

    // Sync flops reset low so a line already low at release never looks like a start edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_q         <= 1'b0;
            rx_s_q          <= 1'b0;
            rx_prev_q       <= 1'b0;
            bstate_q        <= B_IDLE;
            bcnt_q          <= '0;
            bitn_q          <= '0;
            shift_q         <= '0;
            rx_byte_q       <= '0;
            rx_byte_valid_q <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            sync1_q         <= uart_rx;
            rx_s_q          <= sync1_q;
            rx_prev_q       <= rx_s_q;
            rx_byte_valid_q <= 1'b0;
            frame_err_q     <= 1'b0;
            case (bstate_q)
                B_IDLE: begin
                    bcnt_q <= '0;
                    if (rx_prev_q && !rx_s_q) bstate_q <= B_START;
                end
                B_START: begin
                    if (bit_tick) begin
                        bcnt_q   <= '0;
                        bitn_q   <= '0;
                        bstate_q <= rx_s_q ? B_IDLE : B_DATA;
                    end else bcnt_q <= bcnt_q + CW'(1);
                end
                B_DATA: begin
                    if (bit_tick) begin
                        bcnt_q  <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        bitn_q  <= bitn_q + 3'd1;
                        if (bitn_q == 3'd7) bstate_q <= B_STOP;
                    end else bcnt_q <= bcnt_q + CW'(1);
                end
                B_STOP: begin
                    if (bit_tick) begin
                        bcnt_q   <= '0;
                        bstate_q <= B_IDLE;
                        if (rx_s_q) begin
                            rx_byte_q       <= shift_q;
                            rx_byte_valid_q <= 1'b1;
                        end else frame_err_q <= 1'b1;
                    end else bcnt_q <= bcnt_q + CW'(1);
                end
                default: bstate_q <= B_IDLE;
            endcase
        end
    end

    // Framing aborts use the combinational stop_bad so cmd_err lands with frame_err.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pstate_q      <= P_WAIT_HDR;
            gap_q         <= '0;
            op_q          <= '0;
            arg_q         <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_err_q     <= 1'b0;
            cmd_opcode_q  <= '0;
            cmd_arg_q     <= '0;
            uart_active_q <= 1'b0;
            debug_q       <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            gap_q       <= (pstate_q == P_WAIT_HDR) ? '0 : gap_q + TW'(1);
            if (stop_bad && pstate_q != P_WAIT_HDR) begin
                cmd_err_q <= 1'b1;
                pstate_q  <= P_WAIT_HDR;
            end else if (rx_byte_valid_q) begin
                gap_q <= '0;
                case (pstate_q)
                    P_WAIT_HDR: if (rx_byte_q == HDR_BYTE) pstate_q <= P_GET_OP;
                    P_GET_OP: begin
                        op_q     <= rx_byte_q;
                        pstate_q <= P_GET_ARG;
                    end
                    P_GET_ARG: begin
                        arg_q    <= rx_byte_q;
                        pstate_q <= P_GET_SUM;
                    end
                    default: begin
                        pstate_q <= P_WAIT_HDR;
                        if (rx_byte_q == (op_q ^ arg_q)) begin
                            cmd_valid_q  <= 1'b1;
                            cmd_opcode_q <= op_q;
                            cmd_arg_q    <= arg_q;
                            case (op_q)
                                8'h01:   uart_active_q <= 1'b1;
                                8'h02:   uart_active_q <= 1'b0;
                                8'h03:   debug_q       <= arg_q;
                                default: ;
                            endcase
                        end else cmd_err_q <= 1'b1;
                    end
                endcase
            end else if (pstate_q != P_WAIT_HDR && !stop_good && gap_q >= TW'(TO_CYC - 1)) begin
                // A byte about to complete wins over a timeout expiring in the same cycle.
                cmd_err_q <= 1'b1;
                pstate_q  <= P_WAIT_HDR;
            end
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_byte_valid_q;
    assign frame_err     = frame_err_q;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_opcode    = cmd_opcode_q;
    assign cmd_arg       = cmd_arg_q;
    assign cmd_err       = cmd_err_q;
    assign uart_active   = uart_active_q;
    assign debug_out     = debug_q;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomized scoreboard bench for uart_cmd_rx: stimulus pushes expected events from a
// packet-level model, a negedge monitor pops and compares every pulse the DUT emits.
`timescale 1ns/1ps
module tb_uart_cmd_rx;
    localparam int         CLK_NS = 10;
    localparam real        BIT_NS = 100.0;
    localparam logic [7:0] HDR    = 8'hA5;

    logic       clk_in = 1'b0, rst_in = 1'b0, uart_rx = 1'b1;
    logic [7:0] rx_byte, cmd_opcode, cmd_arg, debug_out;
    logic       rx_byte_valid, frame_err, cmd_valid, cmd_err, uart_active;

    always #5 clk_in = ~clk_in;

    uart_cmd_rx #(.CLOCK_RATE(1000), .BAUD_RATE(100), .HDR_BYTE(8'hA5), .TIMEOUT_BITS(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .uart_rx(uart_rx),
        .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .frame_err(frame_err),
        .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .cmd_arg(cmd_arg),
        .cmd_err(cmd_err), .uart_active(uart_active), .debug_out(debug_out));

    typedef enum int {K_BYTE, K_FE, K_FECE, K_CV, K_CE} kind_e;
    typedef struct {
        kind_e      kind;
        logic [7:0] data, op, arg, dbg;
        logic       ua;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pkt[$];
    logic       m_ua  = 1'b0;
    logic [7:0] m_dbg = 8'h00;
    int         checks = 0, passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_ev(input kind_e k, input logic [7:0] d, input logic [7:0] op, input logic [7:0] arg);
        ev_t e;
        e.kind = k; e.data = d; e.op = op; e.arg = arg; e.ua = m_ua; e.dbg = m_dbg;
        exp_q.push_back(e);
    endtask

    // Packet model: collect bytes once a header is seen, judge the packet at four bytes.
    task automatic model_byte(input logic [7:0] b);
        push_ev(K_BYTE, b, 8'h00, 8'h00);
        if (pkt.size() == 0) begin
            if (b == HDR) pkt.push_back(b);
        end else begin
            pkt.push_back(b);
            if (pkt.size() == 4) begin
                if (pkt[3] == (pkt[1] ^ pkt[2])) begin
                    if (pkt[1] == 8'h01) m_ua = 1'b1;
                    if (pkt[1] == 8'h02) m_ua = 1'b0;
                    if (pkt[1] == 8'h03) m_dbg = pkt[2];
                    push_ev(K_CV, 8'h00, pkt[1], pkt[2]);
                end else push_ev(K_CE, 8'h00, 8'h00, 8'h00);
                pkt.delete();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input real bit_ns, input bit stop_ok);
        if (stop_ok) model_byte(b);
        else begin
            push_ev(pkt.size() > 0 ? K_FECE : K_FE, 8'h00, 8'h00, 8'h00);
            pkt.delete();
        end
        uart_rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #(bit_ns);
        end
        uart_rx = stop_ok;
        #(bit_ns);
        uart_rx = 1'b1;
    endtask

    // Idles are either short (<=40 cycles) or long enough (>=400) to be an unambiguous timeout.
    task automatic idle_cycles(input int n);
        uart_rx = 1'b1;
        if (n >= 400 && pkt.size() > 0) begin
            push_ev(K_CE, 8'h00, 8'h00, 8'h00);
            pkt.delete();
        end
        #(n * CLK_NS);
    endtask

    task automatic send_packet(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] sum, input int gap);
        send_byte(HDR, BIT_NS, 1'b1); idle_cycles(gap);
        send_byte(op,  BIT_NS, 1'b1); idle_cycles(gap);
        send_byte(arg, BIT_NS, 1'b1); idle_cycles(gap);
        send_byte(sum, BIT_NS, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_byte"},  rx_byte, 0);
        chk({tag, "_pulses"},   {rx_byte_valid, frame_err, cmd_valid, cmd_err}, 0);
        chk({tag, "_opcode"},   cmd_opcode, 0);
        chk({tag, "_arg"},      cmd_arg, 0);
        chk({tag, "_active"},   uart_active, 0);
        chk({tag, "_debug"},    debug_out, 0);
    endtask

    always @(negedge clk_in) begin
        int    n;
        kind_e k;
        ev_t   e;
        n = int'(rx_byte_valid) + int'(frame_err) + int'(cmd_valid) + int'(cmd_err);
        if (n > 0) begin
            if (n == 2 && frame_err && cmd_err) k = K_FECE;
            else begin
                chk("pulse_exclusive", n, 1);
                k = rx_byte_valid ? K_BYTE : frame_err ? K_FE : cmd_valid ? K_CV : K_CE;
            end
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_event: got kind %0d, expected no event", k);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", k, e.kind);
                case (e.kind)
                    K_BYTE: chk("rx_byte", rx_byte, e.data);
                    K_CV: begin
                        chk("cmd_opcode", cmd_opcode, e.op);
                        chk("cmd_arg", cmd_arg, e.arg);
                        chk("cv_active", uart_active, e.ua);
                        chk("cv_debug", debug_out, e.dbg);
                    end
                    K_CE: chk("ce_active", uart_active, e.ua);
                    default: ;
                endcase
            end
        end
    end

    initial begin
        logic [7:0] op, arg, sum;
        // Reset and idle
        repeat (3) @(posedge clk_in);
        #1 chk_all_zero("reset");
        #2 rst_in = 1'b1;
        idle_cycles(500);
        chk_all_zero("idle");

        // Single byte at nominal and +/-4% bit period
        send_byte(8'h3C, BIT_NS, 1'b1); idle_cycles(20);
        send_byte(8'h3C, 104.0, 1'b1);  idle_cycles(20);
        send_byte(8'h3C, 96.0, 1'b1);   idle_cycles(20);
        chk("skew_rx_byte", rx_byte, 8'h3C);

        // Two valid commands
        send_packet(8'h01, 8'h00, 8'h01, 3); idle_cycles(10);
        send_packet(8'h03, 8'h5A, 8'h59, 0); idle_cycles(20);
        chk("pkt_active", uart_active, 1);
        chk("pkt_debug", debug_out, 8'h5A);
        chk("pkt_opcode", cmd_opcode, 8'h03);
        chk("pkt_arg", cmd_arg, 8'h5A);

        // Bad checksum
        send_packet(8'h02, 8'h00, 8'h03, 0); idle_cycles(20);
        chk("badsum_active", uart_active, 1);
        chk("badsum_opcode", cmd_opcode, 8'h03);

        // Framing error on the argument byte, then recovery
        send_byte(HDR, BIT_NS, 1'b1);
        send_byte(8'h01, BIT_NS, 1'b1);
        send_byte(8'h22, BIT_NS, 1'b0); idle_cycles(30);
        send_packet(8'h03, 8'h77, 8'h74, 0); idle_cycles(20);
        chk("fe_recover_debug", debug_out, 8'h77);
        chk("fe_active", uart_active, 1);

        // Short glitch on an idle line
        uart_rx = 1'b0; #(3 * CLK_NS); idle_cycles(50);

        // Inter-byte timeout, then recovery
        send_byte(HDR, BIT_NS, 1'b1);
        send_byte(8'h01, BIT_NS, 1'b1);
        idle_cycles(400);
        send_packet(8'h02, 8'h00, 8'h02, 0); idle_cycles(20);
        chk("timeout_recover_active", uart_active, 0);

        // Random packets, junk bytes and gaps
        for (int p = 0; p < 25; p++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_byte(8'($urandom), BIT_NS, 1'b1);
                idle_cycles($urandom_range(0, 20));
            end
            case ($urandom_range(0, 3))
                0: op = 8'h01;
                1: op = 8'h02;
                2: op = 8'h03;
                default: op = 8'($urandom);
            endcase
            arg = 8'($urandom);
            sum = op ^ arg;
            if ($urandom_range(0, 4) == 0) sum = sum ^ (8'h01 << $urandom_range(0, 7));
            send_packet(op, arg, sum, $urandom_range(0, 20));
            idle_cycles($urandom_range(0, 20));
        end
        idle_cycles(400);
        chk("rand_active", uart_active, m_ua);
        chk("rand_debug", debug_out, m_dbg);

        // Reset mid-byte
        send_packet(8'h01, 8'h00, 8'h01, 0); idle_cycles(20);
        uart_rx = 1'b0; #(BIT_NS);
        uart_rx = 1'b1; #(BIT_NS);
        uart_rx = 1'b0; #(50);
        rst_in = 1'b0;
        pkt.delete(); m_ua = 1'b0; m_dbg = 8'h00;
        #1 chk_all_zero("midreset");
        uart_rx = 1'b1; #(53);
        rst_in = 1'b1;
        idle_cycles(300);
        send_packet(8'h03, 8'h11, 8'h12, 0); idle_cycles(20);
        chk("post_reset_debug", debug_out, 8'h11);
        chk("post_reset_active", uart_active, 0);

        for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(posedge clk_in);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Host-to-board UART receiver and command decoder for the tactile-sensing array, and the receive-side counterpart of the sensor-data UART transmitter. It deserialises 8N1 bytes on `uart_rx` at the same `CLOCK_RATE`/`BAUD_RATE` as the transmitter. It parses 4-byte command packets (header, opcode, argument, checksum) and drives the transmitter's `uart_active` and `debug_in` controls from registered state.

## Interface
- `CLOCK_RATE`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115_200: serial bit rate; `CYC_PER_BIT = CLOCK_RATE / BAUD_RATE` (integer division, truncated), must be ≥ 4.
- `HDR_BYTE`, default 8'hA5: packet header value.
- `TIMEOUT_BITS`, default 32: maximum inter-byte gap inside a packet, in bit periods.
- `clk_in` input 1: system clock; all logic on its rising edge.
- `rst_in` input 1: asynchronous, active-low reset. Asserting low clears all state immediately; release is sampled on `clk_in`.
- `uart_rx` input 1: asynchronous serial line; idles high.
- `rx_byte` output 8: last received byte; valid while `rx_byte_valid` is high, held afterwards.
- `rx_byte_valid` output 1: one-cycle pulse per correctly framed byte.
- `frame_err` output 1: one-cycle pulse when a stop bit samples low.
- `cmd_valid` output 1: one-cycle pulse per packet that passes checksum.
- `cmd_opcode` output 8: opcode of last valid packet.
- `cmd_arg` output 8: argument of last valid packet.
- `cmd_err` output 1: one-cycle pulse on checksum mismatch, timeout abort, or framing-error abort.
- `uart_active` output 1: streaming enable to the transmitter.
- `debug_out` output 8: debug byte to the transmitter's `debug_in`.

## Operation
- Input sync: `uart_rx` passes through two flops to give `rx_s`. All decisions use `rx_s`.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on `rx_s` falling edge, but only if `rx_s` was high in the previous cycle. A line held low never re-triggers.
  - START: wait `CYC_PER_BIT/2` cycles, then sample. If low → DATA. If high → IDLE; treat as a glitch with no error.
  - DATA: sample every `CYC_PER_BIT` cycles, 8 samples, LSB first, shifted into `rx_byte` shadow.
  - STOP: sample after `CYC_PER_BIT`. If high → `rx_byte_valid` pulse. If low → `frame_err` pulse and the byte is discarded. Both cases go to IDLE.
- Packet FSM states: WAIT_HDR, GET_OP, GET_ARG, GET_SUM. It advances only on `rx_byte_valid`.
  - WAIT_HDR: a byte equal to `HDR_BYTE` → GET_OP. Other bytes are ignored silently.
  - GET_OP: latch the opcode. GET_ARG: latch the argument.
  - GET_SUM: if `sum == op ^ arg`, pulse `cmd_valid`, update `cmd_opcode`/`cmd_arg`, and execute the command. Otherwise pulse `cmd_err`. Both cases go to WAIT_HDR.
  - `HDR_BYTE` appearing in the op, arg, or sum position is plain data, not a resync.
- Commands:
  - 8'h01: set `uart_active`=1.
  - 8'h02: set `uart_active`=0.
  - 8'h03: set `debug_out`=arg.
  - Any other opcode: `cmd_valid` still pulses, but there is no state change.
- Timeout: the gap counter runs while the packet FSM is not in WAIT_HDR and resets on every `rx_byte_valid`. Reaching `TIMEOUT_BITS*CYC_PER_BIT` → `cmd_err` pulse, go to WAIT_HDR.
- A `frame_err` while the packet FSM is not in WAIT_HDR → `cmd_err` pulse in the same cycle, go to WAIT_HDR.

## Timing
- Reset values: `rx_byte`=0, `rx_byte_valid`=0, `frame_err`=0, `cmd_valid`=0, `cmd_opcode`=0, `cmd_arg`=0, `cmd_err`=0, `uart_active`=0, `debug_out`=0. Both FSMs start in IDLE/WAIT_HDR, and all counters are 0.
- Latency from the `uart_rx` falling edge to `rx_byte_valid`: 2 (sync) + 1 (edge) + `CYC_PER_BIT/2` + 9·`CYC_PER_BIT` + 1 cycles, ±1.
- `cmd_valid`, `cmd_err`, and the command effect (`uart_active`/`debug_out`) occur 1 cycle after the checksum byte's `rx_byte_valid`. Command outputs update on that same edge.
- Back-to-back bytes with zero idle time between stop and next start are received without loss.
- Reset asserted mid-byte or mid-packet aborts immediately, with no pulses. After release, reception restarts only at a fresh high→low transition.
- All pulse outputs are exactly one cycle wide, and the pulse outputs are mutually exclusive in any cycle except `frame_err`+`cmd_err`.

## Test plan
Bench parameters: CLOCK_RATE=1000, BAUD_RATE=100 (10 cycles/bit).

- Reset and idle: hold `rst_in` low, then release with `uart_rx`=1 for 500 cycles. Required: all outputs stay 0 and there are no pulses.
- Single byte 8'h3C at exact baud. Required: one `rx_byte_valid`, `rx_byte`=8'h3C. Repeat at +4%/−4% bit-period skew; the result must be identical.
- Packet A5 01 00 01, then A5 03 5A 59. Required: two `cmd_valid` pulses, `uart_active`=1, `debug_out`=8'h5A, `cmd_opcode`=8'h03, `cmd_arg`=8'h5A.
- Packet A5 02 00 03 (bad sum). Required: one `cmd_err`, no `cmd_valid`, `uart_active` unchanged.
- Stop bit driven low inside GET_ARG. Required: `frame_err` and `cmd_err` in the same cycle, FSM in WAIT_HDR. A following valid packet must decode. A 3-cycle low glitch on an idle line must produce no pulse.
- Timeouts and reset mid-operation:
  - A5 01, then idle for 320 cycles. Required: `cmd_err` once, then A5 02 00 02 decodes.
  - `rst_in` pulsed low mid-byte. Required: immediate clear, no spurious `rx_byte_valid`.
